// File: rtl/alu16_pkg.sv
// Shared constants for the 16-bit ALU: default width, NZVC flag bit positions and op-codes.
package alu16_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_NEG = 1'b1
  } alu_op_e;

endpackage

// File: rtl/adder_16bits.sv
// Ripple-carry adder built from full-adder cells; exposes carry into and out of the MSB
// so the caller can derive signed overflow.
module adder_16bits
  import alu16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout  = carry[WIDTH];
  assign c_msb = carry[WIDTH-1];

endmodule

// File: rtl/alu_16bits.sv
// Add / negate-B ALU sharing one adder, with combinational NZVC flags and an optional
// registered status copy enabled by the ALU16_FLAG_REG_EN macro.
module alu_16bits
  import alu16_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ALU_CTRL,
  output logic [WIDTH-1:0] S,
  output logic [3:0]       NZVC,
  output logic [3:0]       NZVC_Q
);

  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             carry_out;
  logic             carry_msb;

  // Negation is 0 + ~B + 1, so both ops reuse the same adder with carry-in = ALU_CTRL.
  assign op_x = (ALU_CTRL == OP_NEG) ? '0 : A;
  assign op_y = (ALU_CTRL == OP_NEG) ? ~B : B;

  adder_16bits #(.WIDTH(WIDTH)) u_adder (
    .a     (op_x),
    .b     (op_y),
    .cin   (ALU_CTRL),
    .sum   (S),
    .cout  (carry_out),
    .c_msb (carry_msb)
  );

  always_comb begin
    NZVC         = '0;
    NZVC[FLAG_N] = S[WIDTH-1];
    NZVC[FLAG_Z] = (S == '0);
    NZVC[FLAG_V] = carry_msb ^ carry_out;
    NZVC[FLAG_C] = carry_out;
  end

`ifdef ALU16_FLAG_REG_EN
  logic [3:0] nzvc_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      nzvc_q_reg <= '0;
    end else begin
      nzvc_q_reg <= NZVC;
    end
  end

  assign NZVC_Q = nzvc_q_reg;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign NZVC_Q         = '0;
`endif

endmodule

// File: tb/tb_alu_16bits.sv
// Scoreboard bench for alu_16bits: directed boundary vectors then random traffic,
// checked against an integer-arithmetic reference model.
module tb_alu_16bits;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        ctrl;
  logic [15:0] s;
  logic [3:0]  nzvc;
  logic [3:0]  nzvc_q;

  alu_16bits #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .ALU_CTRL (ctrl),
    .S        (s),
    .NZVC     (nzvc),
    .NZVC_Q   (nzvc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        ctrl;
    logic [15:0] exp_s;
    logic [3:0]  exp_nzvc;
    logic [3:0]  exp_q;
  } txn_t;

  txn_t exp_queue[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] model_q;

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  function automatic logic [19:0] ref_model(logic [15:0] ra, logic [15:0] rb, logic rc);
    int ua, ub, sa, sb, us, ss;
    logic [15:0] rs;
    logic n, z, v, c;
    ua = int'(ra);
    ub = int'(rb);
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (!rc) begin
      us = ua + ub;
      ss = sa + sb;
      rs = 16'(us);
      c  = (us > 65535);
      v  = (ss > 32767) || (ss < -32768);
    end else begin
      ss = -sb;
      rs = 16'(65536 - ub);
      c  = (ub == 0);
      v  = (ss > 32767);
    end
    n = rs[15];
    z = (rs == 16'h0000);
    return {rs, n, z, v, c};
  endfunction

  task automatic check(string name, int idx, logic [15:0] got, logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s txn %0d: got 0x%04h, expected 0x%04h", name, idx, got, want);
    end
  endtask

  // Drive one transaction just after a rising edge and queue what must be seen.
  task automatic drive(int idx, logic r, logic [15:0] ta, logic [15:0] tb_v, logic tc,
                       logic [15:0] es, logic [3:0] en);
    txn_t t;
    #1;
    rst  = r;
    a    = ta;
    b    = tb_v;
    ctrl = tc;
    t.idx = idx; t.a = ta; t.b = tb_v; t.ctrl = tc;
    t.exp_s = es; t.exp_nzvc = en; t.exp_q = model_q;
    exp_queue.push_back(t);
`ifdef ALU16_FLAG_REG_EN
    model_q = r ? 4'b0000 : en;
`else
    model_q = 4'b0000;
`endif
    @(posedge clk);
  endtask

  // Monitor: combinational outputs are stable by the falling edge.
  always @(negedge clk) begin
    if (exp_queue.size() > 0) begin
      txn_t t;
      t = exp_queue.pop_front();
      $display("txn %0d: A=%04h B=%04h CTRL=%0d rst=%0d -> S=%04h NZVC=%04b NZVC_Q=%04b",
               t.idx, t.a, t.b, t.ctrl, rst, s, nzvc, nzvc_q);
      check("S", t.idx, s, t.exp_s);
      check("NZVC", t.idx, {12'h0, nzvc}, {12'h0, t.exp_nzvc});
      check("NZVC_Q", t.idx, {12'h0, nzvc_q}, {12'h0, t.exp_q});
    end
  end

  logic [15:0] dir_a   [7] = '{16'h0001, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'hABCD, 16'h5555};
  logic [15:0] dir_b   [7] = '{16'h0002, 16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h8000, 16'h0000};
  logic        dir_c   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] dir_s   [7] = '{16'h0003, 16'h8000, 16'h0000, 16'hFFFB, 16'hFFFB, 16'h8000, 16'h0000};
  logic [3:0]  dir_f   [7] = '{4'b0000, 4'b1010, 4'b0101, 4'b1000, 4'b1000, 4'b1010, 4'b0101};

  initial begin
    logic [19:0] r;
    logic [15:0] ra, rb;
    logic        rc, rr;
    logic [15:0] corner [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};
    int idx;
    rst = 1'b1; a = '0; b = '0; ctrl = 1'b0;
    model_q = 4'b0000;
    @(posedge clk);
    idx = 0;
    // First vector under reset, so the 7FFF+1 case shows NZVC_Q=0000 until the following edge.
    for (int i = 0; i < 7; i++) begin
      drive(idx, (i == 0), dir_a[i], dir_b[i], dir_c[i], dir_s[i], dir_f[i]);
      idx++;
    end
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 19) == 0);
      r  = ref_model(ra, rb, rc);
      drive(idx, rr, ra, rb, rc, r[19:4], r[3:0]);
      idx++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10 && exp_queue.size() > 0; i++) @(posedge clk);
    check("queue_drained", idx, 16'(exp_queue.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_16bits.md
ALU_16BITS -- requirements
Module: alu_16bits

Interface
REQ-001 Parameter WIDTH, default 16, data width of A, B and S; all rules below are stated for 16 and scale with WIDTH.
REQ-002 clk  input  1  single clock; the flag register is the only sequential state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  16  operand A, two's complement or unsigned.
REQ-005 B  input  16  operand B, two's complement or unsigned.
REQ-006 ALU_CTRL  input  1  operation select: 0 = add, 1 = negate B.
REQ-007 S  output  16  result, combinational.
REQ-008 NZVC  output  4  combinational flags for S: [3]=N, [2]=Z, [1]=V, [0]=C.
REQ-009 NZVC_Q  output  4  registered copy of NZVC (status register), same bit order.

Function
REQ-010 With ALU_CTRL=0, S SHALL be (A + B) mod 2^16.
REQ-011 With ALU_CTRL=1, S SHALL be (~B + 1) mod 2^16, the two's complement of B; A is ignored.
REQ-012 Both operations SHALL use one shared 16-bit adder: operand X = A or 0, operand Y = B or ~B, carry-in = ALU_CTRL.
REQ-013 N SHALL equal S[15].
REQ-014 Z SHALL be 1 exactly when S = 0x0000.
REQ-015 C SHALL equal the carry out of bit 15 of the shared adder.
  - Add: C = 1 when unsigned A + B > 0xFFFF.
  - Negate: C = 1 only when B = 0x0000.
REQ-016 V SHALL equal carry-in XOR carry-out of bit 15, i.e. signed overflow.
  - Add: two same-sign operands give a result of the other sign.
  - Negate: V = 1 only when B = 0x8000.
REQ-017 S and NZVC SHALL be purely combinational; they settle within the same cycle as an input change, independent of clk and rst.
REQ-018 On each rising clk edge with rst=0, NZVC_Q SHALL load the current NZVC; latency is one cycle.
REQ-019 No X SHALL propagate to S or NZVC from known inputs; ALU_CTRL is fully decoded (0 or 1).

Reset
REQ-020 While rst=1 at a rising clk edge, NZVC_Q SHALL become 4'b0000.
REQ-021 rst SHALL NOT affect S or NZVC.
REQ-022 Deasserting rst SHALL resume normal loading of NZVC_Q at the next edge.

Configuration
REQ-023 Macro ALU16_FLAG_REG_EN: when defined, the NZVC_Q register SHALL be implemented per REQ-018 and REQ-020.
REQ-024 When ALU16_FLAG_REG_EN is undefined, NZVC_Q SHALL be tied to 4'b0000 and no flip-flops SHALL be inferred; S and NZVC are unchanged.

Structure
REQ-025 A shared package alu16_pkg SHALL hold:
  - the WIDTH default;
  - the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0;
  - the op-code constants OP_ADD=1'b0, OP_NEG=1'b1.
REQ-026 One sub-module, adder_16bits, SHALL be used: a ripple-carry adder of full-adder cells that exposes the sum, carry-out of bit 15, and carry-into bit 15 for V.

Verification
REQ-027 A=0x0001, B=0x0002, CTRL=0 -> S=0x0003, NZVC=0000.
REQ-028 A=0x7FFF, B=0x0001, CTRL=0 -> S=0x8000, NZVC=1010.
REQ-029 A=0xFFFF, B=0x0001, CTRL=0 -> S=0x0000, NZVC=0101.
REQ-030 A=0x0000, B=0x0005, CTRL=1 -> S=0xFFFB, NZVC=1000; A=0x1234 with the same B gives the identical result.
REQ-031 CTRL=1 boundary cases:
  - B=0x8000 -> S=0x8000, NZVC=1010.
  - B=0x0000 -> S=0x0000, NZVC=0101.
REQ-032 Flag register, with ALU16_FLAG_REG_EN defined:
  - rst=1 for one edge -> NZVC_Q=0000.
  - Then apply REQ-028 stimulus -> NZVC_Q=1010 after the next edge, not before.
